// File: rtl/dmem_lsu.sv
// Load/store initiator for a word-wide dmem: sub-word loads are extracted and extended, and sub-word stores become read-modify-write.
// Latency from accept to response: load and SW 2 cycles, SB and SH 3 cycles, errors 1 cycle. One request in flight; req_ready is high only in IDLE.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data_q, data_d;
    logic                  err_q, err_d;

    logic                  req_bad, req_misal;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_val, merge_val;
    logic                  is_sw;

    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_bad = 1'b0;
            3'b100, 3'b101:         req_bad = req_we;
            default:                req_bad = 1'b1;
        endcase
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    end

    // Lane extraction and merge both work off the registered address.
    always_comb begin
        rd_byte = mem_rd[7:0];
        case (addr_q[1:0])
            2'd0: rd_byte = mem_rd[7:0];
            2'd1: rd_byte = mem_rd[15:8];
            2'd2: rd_byte = mem_rd[23:16];
            2'd3: rd_byte = mem_rd[31:24];
            default: rd_byte = mem_rd[7:0];
        endcase
        rd_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        load_val = mem_rd;
        case (funct3_q)
            3'b000: load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001: load_val = {{16{rd_half[15]}}, rd_half};
            3'b100: load_val = {24'd0, rd_byte};
            3'b101: load_val = {16'd0, rd_half};
            default: load_val = mem_rd;
        endcase

        merge_val = mem_rd;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merge_val[7:0]   = wdata_q[7:0];
                2'd1: merge_val[15:8]  = wdata_q[7:0];
                2'd2: merge_val[23:16] = wdata_q[7:0];
                2'd3: merge_val[31:24] = wdata_q[7:0];
                default: merge_val = mem_rd;
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    assign is_sw = we_q && (funct3_q == 3'b010);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    data_d   = 32'd0;
                    err_d    = req_bad || req_misal;
                    state_d  = (req_bad || req_misal) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    data_d  = load_val;
                    state_d = RESP;
                end else if (is_sw) begin
                    state_d = RESP;
                end else begin
                    data_d  = merge_val;
                    state_d = MERGE_WR;
                end
            end
            MERGE_WR: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Memory-side outputs decode only registered state, so reset drops mem_we at once.
    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_a      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_we     = 1'b0;
        mem_wd     = 32'd0;
        if (state_q == ACCESS && is_sw) begin
            mem_we = 1'b1;
            mem_wd = wdata_q;
        end else if (state_q == MERGE_WR) begin
            mem_we = 1'b1;
            mem_wd = data_q;
        end
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? data_q : 32'd0;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small word-array dmem model attached.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:15];
    logic        mem_clr;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int resp_cnt = 0;
    int w0, r0;

    dmem_lsu #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            mem[mem_a[5:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a[5:2]];

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (resp_valid) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_we);
        int lat;
        int wbase;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        wbase = we_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_we"}, we_cnt - wbase, exp_we);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_clr    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        rst_n   = 1'b1;

        do_req("sw0", 1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        chk("sw0_mem", mem[0], 32'hDEADBEEF);
        do_req("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

        do_req("sb2", 1'b1, 3'b000, 32'h2, 32'h123456AA, 3, 32'h0, 1'b0, 1);
        chk("sb2_mem", mem[0], 32'hDEAABEEF);
        do_req("lb2", 1'b0, 3'b000, 32'h2, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 0);
        do_req("lbu2", 1'b0, 3'b100, 32'h2, 32'h0, 2, 32'h000000AA, 1'b0, 0);

        do_req("sw4", 1'b1, 3'b010, 32'h4, 32'hCAFEBABE, 2, 32'h0, 1'b0, 1);
        do_req("sh6", 1'b1, 3'b001, 32'h6, 32'hFFFF1234, 3, 32'h0, 1'b0, 1);
        chk("sh6_mem", mem[1], 32'h1234BABE);
        do_req("lh4", 1'b0, 3'b001, 32'h4, 32'h0, 2, 32'hFFFFBABE, 1'b0, 0);
        do_req("lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 2, 32'h00001234, 1'b0, 0);

        do_req("lw3_mis", 1'b0, 3'b010, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req("sh5_mis", 1'b1, 3'b001, 32'h5, 32'h00007777, 1, 32'h0, 1'b1, 0);
        do_req("f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req("sbu_ill", 1'b1, 3'b100, 32'h0, 32'h00000099, 1, 32'h0, 1'b1, 0);
        chk("err_mem0", mem[0], 32'hDEAABEEF);
        chk("err_mem1", mem[1], 32'h1234BABE);

        w0 = we_cnt;
        r0 = resp_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8;
        req_wdata  = 32'h11223344;
        @(posedge clk); #1;
        req_we = 1'b0;
        chk("b2b_rdy_access", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_rdy_resp", {31'd0, req_ready}, 32'd0);
        chk("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("b2b_rdy_idle", {31'd0, req_ready}, 32'd1);
        chk("b2b_gap", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_rdy_access2", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        chk("b2b_rdata", resp_rdata, 32'h11223344);
        @(posedge clk); #1;
        chk("b2b_resp_cnt", resp_cnt - r0, 32'd2);
        chk("b2b_we_cnt", we_cnt - w0, 32'd1);
        chk("b2b_mem", mem[2], 32'h11223344);

        r0 = resp_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h1;
        req_wdata  = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_merge_we", {31'd0, mem_we}, 32'd1);
        chk("rst_merge_wd", mem_wd, 32'hDEAA55EF);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'd0, mem_we}, 32'd0);
        chk("rst_async_wd", mem_wd, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mem_kept", mem[0], 32'hDEAABEEF);
        chk("rst_no_resp", resp_cnt - r0, 32'd0);
        chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
